// File: rtl/key_event_ctrl.sv
// Key event controller: turns a debounced active-low key vector into a
// queued stream of press / release / long-press / auto-repeat events.
// Per-key pending flags are drained into a small event FIFO by a
// round-robin arbiter; the consumer pops the FIFO with valid/ready.
module key_event_ctrl #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned KEY_CNT    = 8,
  parameter int unsigned LONG_MS    = 1000,
  parameter int unsigned REPEAT_MS  = 200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [KEY_CNT-1:0]         keys_stable,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [$clog2(KEY_CNT)-1:0] evt_key,
  output logic [1:0]                 evt_type,
  output logic                       evt_overflow,
  input  logic                       ovf_clr
);

  localparam int unsigned KW       = $clog2(KEY_CNT);
  localparam int unsigned PRESC    = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
  localparam int unsigned PW       = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int unsigned HOLD_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
  localparam int unsigned CW       = $clog2(HOLD_MAX + 1);
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  // Type codes double as the bit index of each key's pending-flag nibble.
  typedef enum logic [1:0] {
    EVT_PRESS   = 2'b00,
    EVT_RELEASE = 2'b01,
    EVT_LONG    = 2'b10,
    EVT_REPEAT  = 2'b11
  } evt_t;

  logic [KEY_CNT-1:0]      key_q, key_qq;
  logic [KEY_CNT-1:0]      press_edge, release_edge;
  logic [KEY_CNT-1:0]      long_hit, repeat_hit;
  logic [KEY_CNT-1:0][3:0] ev, pend, gnt_mask;
  logic [PW-1:0]           presc;
  logic                    tick;
  logic                    drop;

  logic                    gnt;
  logic [KW-1:0]           gnt_key;
  evt_t                    gnt_type;
  logic [KW-1:0]           arb_idx;
  logic [KW-1:0]           rr_ptr;

  logic [KW+1:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             fifo_cnt;
  logic [KW+1:0]           head;
  logic                    push, pop;

  // Two-stage key sampling; reset value models all keys released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q  <= '1;
      key_qq <= '1;
    end else begin
      key_q  <= keys_stable;
      key_qq <= key_q;
    end
  end

  assign press_edge   = key_qq & ~key_q;
  assign release_edge = ~key_qq & key_q;

  // 1 ms prescaler; tick is high during the terminal-count cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  assign tick = (presc == PW'(PRESC - 1));

  for (genvar k = 0; k < KEY_CNT; k++) begin : g_key
    logic [CW-1:0] hold_cnt;
    logic          long_done;

    assign long_hit[k]   = tick & ~key_q[k] & ~press_edge[k] & ~long_done &
                           (hold_cnt == CW'(LONG_MS - 1));
    assign repeat_hit[k] = tick & ~key_q[k] & ~press_edge[k] & long_done &
                           (hold_cnt == CW'(REPEAT_MS - 1));
    assign ev[k]         = {repeat_hit[k], long_hit[k], release_edge[k], press_edge[k]};

    // Hold timer: counts to the long threshold once, then restarts for each
    // repeat period, so it never needs more than max(LONG, REPEAT) range.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_cnt  <= '0;
        long_done <= 1'b0;
      end else if (key_q[k] || press_edge[k]) begin
        hold_cnt  <= '0;
        long_done <= 1'b0;
      end else if (tick) begin
        if (long_hit[k]) begin
          hold_cnt  <= '0;
          long_done <= 1'b1;
        end else if (repeat_hit[k]) begin
          hold_cnt  <= '0;
        end else begin
          hold_cnt  <= hold_cnt + 1'b1;
        end
      end
    end
  end

  // Round-robin key choice from rr_ptr, then fixed type priority within the key.
  always_comb begin
    gnt      = 1'b0;
    gnt_key  = '0;
    gnt_type = EVT_PRESS;
    arb_idx  = '0;
    if (fifo_cnt < CNT_FULL) begin
      for (int unsigned i = 0; i < KEY_CNT; i++) begin
        arb_idx = KW'((32'(rr_ptr) + i) % KEY_CNT);
        if (!gnt && (|pend[arb_idx])) begin
          gnt     = 1'b1;
          gnt_key = arb_idx;
          if (pend[arb_idx][EVT_PRESS])       gnt_type = EVT_PRESS;
          else if (pend[arb_idx][EVT_LONG])   gnt_type = EVT_LONG;
          else if (pend[arb_idx][EVT_REPEAT]) gnt_type = EVT_REPEAT;
          else                                gnt_type = EVT_RELEASE;
        end
      end
    end
  end

  // One-hot view of this cycle's grant for flag clearing and drop detection.
  always_comb begin
    gnt_mask = '0;
    if (gnt) gnt_mask[gnt_key][gnt_type] = 1'b1;
  end

  // An event hitting a flag that stays pending (not granted now) is lost.
  assign drop = |(ev & pend & ~gnt_mask);

  // Pending flags: a new event wins over a same-cycle grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= ev | (pend & ~gnt_mask);
  end

  // Round-robin pointer moves just past the granted key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (gnt) begin
      rr_ptr <= (gnt_key == KW'(KEY_CNT - 1)) ? '0 : gnt_key + 1'b1;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) evt_overflow <= 1'b0;
    else        evt_overflow <= (evt_overflow & ~ovf_clr) | drop;
  end

  assign push = gnt;
  assign pop  = evt_valid & evt_ready;

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {gnt_key, gnt_type};
  end

  assign head      = mem[rd_ptr];
  assign evt_valid = (fifo_cnt != '0);
  assign evt_key   = evt_valid ? head[KW+1:2] : '0;
  assign evt_type  = evt_valid ? head[1:0]    : 2'b00;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Testbench for key_event_ctrl: directed scenarios plus randomized key
// activity, checked by a reference model feeding an expected-event queue.
module tb_key_event_ctrl;

  localparam int unsigned CLK_FREQ   = 3000;
  localparam int unsigned KEY_CNT    = 8;
  localparam int unsigned LONG_MS    = 30;
  localparam int unsigned REPEAT_MS  = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PRESC      = CLK_FREQ / 1000;
  localparam int unsigned KW         = $clog2(KEY_CNT);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [KEY_CNT-1:0] keys_stable = '1;
  logic               evt_ready = 1'b0;
  logic               ovf_clr = 1'b0;
  logic               evt_valid;
  logic [KW-1:0]      evt_key;
  logic [1:0]         evt_type;
  logic               evt_overflow;

  key_event_ctrl #(
    .CLK_FREQ  (CLK_FREQ),
    .KEY_CNT   (KEY_CNT),
    .LONG_MS   (LONG_MS),
    .REPEAT_MS (REPEAT_MS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .keys_stable (keys_stable),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_key     (evt_key),
    .evt_type    (evt_type),
    .evt_overflow(evt_overflow),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [KW+1:0] exp_q[$];
  logic [KW+1:0] seen_q[$];
  logic [KW+1:0] want_q[$];

  // Reference model state
  bit       m_kq   [KEY_CNT];
  bit       m_kqq  [KEY_CNT];
  bit [3:0] m_pend [KEY_CNT];
  int       m_held [KEY_CNT];
  int       m_cyc, m_ptr, m_count;
  bit       m_ovf;

  function automatic logic [KW+1:0] ent(input int k, input int t);
    return {KW'(k), 2'(t)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < KEY_CNT; k++) begin
      m_kq[k] = 1'b1; m_kqq[k] = 1'b1; m_pend[k] = 4'b0; m_held[k] = 0;
    end
    m_cyc = 0; m_ptr = 0; m_count = 0; m_ovf = 1'b0;
    exp_q.delete();
  endtask

  // Behavioural model: hold time tracked as total ticks since press;
  // long at LONG_MS ticks, repeats every REPEAT_MS ticks after that.
  task automatic model_step();
    bit ev [KEY_CNT][4];
    bit tick, press, drop, pop, found;
    int gk, gt, k;
    int prio [4];
    prio[0] = 0; prio[1] = 2; prio[2] = 3; prio[3] = 1;
    tick = ((m_cyc % PRESC) == PRESC - 1);
    m_cyc++;
    for (int i = 0; i < KEY_CNT; i++) begin
      for (int t = 0; t < 4; t++) ev[i][t] = 1'b0;
      press = m_kqq[i] && !m_kq[i];
      if (press) ev[i][0] = 1'b1;
      if (!m_kqq[i] && m_kq[i]) ev[i][1] = 1'b1;
      if (m_kq[i] || press) m_held[i] = 0;
      else if (tick) begin
        m_held[i]++;
        if (m_held[i] == LONG_MS) ev[i][2] = 1'b1;
        else if (m_held[i] > LONG_MS && ((m_held[i] - LONG_MS) % REPEAT_MS) == 0) ev[i][3] = 1'b1;
      end
    end
    gk = -1; gt = 0;
    if (m_count < FIFO_DEPTH) begin
      for (int i = 0; i < KEY_CNT; i++) begin
        k = (m_ptr + i) % KEY_CNT;
        if (gk < 0 && m_pend[k] != 4'b0) begin
          gk = k; found = 1'b0;
          for (int p = 0; p < 4; p++)
            if (!found && m_pend[k][prio[p]]) begin gt = prio[p]; found = 1'b1; end
        end
      end
    end
    drop = 1'b0;
    for (int i = 0; i < KEY_CNT; i++)
      for (int t = 0; t < 4; t++) begin
        if (ev[i][t]) begin
          if (m_pend[i][t] && !(i == gk && t == gt)) drop = 1'b1;
          m_pend[i][t] = 1'b1;
        end else if (i == gk && t == gt) m_pend[i][t] = 1'b0;
      end
    m_ovf = (m_ovf && !ovf_clr) || drop;
    pop = (m_count != 0) && evt_ready;
    if (gk >= 0) begin
      exp_q.push_back(ent(gk, gt));
      m_ptr = (gk + 1) % KEY_CNT;
      m_count++;
    end
    if (pop) m_count--;
    for (int i = 0; i < KEY_CNT; i++) begin
      m_kqq[i] = m_kq[i];
      m_kq[i]  = keys_stable[i];
    end
  endtask

  function automatic bit model_idle();
    bit idle;
    idle = (m_count == 0) && (exp_q.size() == 0);
    for (int k = 0; k < KEY_CNT; k++) if (m_pend[k] != 4'b0) idle = 1'b0;
    return idle;
  endfunction

  // Model advance on each active edge
  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Monitor: compares DUT outputs with the model and pops on handshakes
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs", {evt_valid, evt_key, evt_type, evt_overflow}, '0);
    end else begin
      check("valid", evt_valid, (m_count != 0));
      check("overflow", evt_overflow, m_ovf);
      if (evt_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {evt_key, evt_type}, '1);
        end else begin
          check("head", {evt_key, evt_type}, exp_q[0]);
          if (evt_ready) begin
            seen_q.push_back({evt_key, evt_type});
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    cyc(4);
    while (!model_idle() && n < 2000) begin cyc(1); n++; end
    if (!model_idle()) check("drain_timeout", 32'd1, 32'd0);
    cyc(2);
  endtask

  task automatic want(input int k, input int t);
    want_q.push_back(ent(k, t));
  endtask

  task automatic expect_seen(input string name);
    check({name, "_count"}, seen_q.size(), want_q.size());
    for (int i = 0; i < want_q.size() && i < seen_q.size(); i++)
      check(name, seen_q[i], want_q[i]);
    want_q.delete();
    seen_q.delete();
  endtask

  int rem [KEY_CNT];

  initial begin
    model_reset();
    cyc(3);
    check("rst_state", {evt_valid, evt_key, evt_type, evt_overflow}, '0);
    rst_n = 1'b1;
    cyc(5);

    // Simultaneous presses of 1,5,6 from pointer 0, with latency check
    evt_ready = 1'b1;
    seen_q.delete();
    keys_stable[1] = 1'b0; keys_stable[5] = 1'b0; keys_stable[6] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("latency_n2", evt_valid, 1'b0);
    @(posedge clk); #1;
    check("latency_n3", evt_valid, 1'b1);
    check("latency_head", {evt_key, evt_type}, ent(1, 0));
    #1;
    cyc(10);
    keys_stable = '1;
    wait_drain();
    want(1, 0); want(5, 0); want(6, 0); want(1, 1); want(5, 1); want(6, 1);
    expect_seen("rr_156");

    // Pointer now 7: key 7 must win over key 0
    keys_stable[0] = 1'b0; keys_stable[7] = 1'b0;
    cyc(10);
    keys_stable = '1;
    wait_drain();
    want(7, 0); want(0, 0); want(7, 1); want(0, 1);
    expect_seen("rr_ptr7");

    // Long press with two repeats on key 0
    keys_stable[0] = 1'b0;
    cyc(150);
    keys_stable[0] = 1'b1;
    wait_drain();
    want(0, 0); want(0, 2); want(0, 3); want(0, 3); want(0, 1);
    expect_seen("long_repeat");

    // Six presses with consumer stalled; pointer is 1
    evt_ready = 1'b0;
    keys_stable = 8'b1100_0000;
    cyc(8);
    for (int i = 0; i < 20; i++) begin
      check("stall_valid", evt_valid, 1'b1);
      check("stall_head", {evt_key, evt_type}, ent(1, 0));
      cyc(1);
    end
    evt_ready = 1'b1;
    cyc(10);
    check("stall_no_ovf", evt_overflow, 1'b0);
    want(1, 0); want(2, 0); want(3, 0); want(4, 0); want(5, 0); want(0, 0);
    expect_seen("stall_drain");
    keys_stable = '1;
    wait_drain();
    seen_q.delete();

    // Overflow: FIFO full, key 2 press/release/press
    evt_ready = 1'b0;
    keys_stable = 8'b0000_1111;
    cyc(10);
    keys_stable[2] = 1'b0; cyc(10);
    keys_stable[2] = 1'b1; cyc(10);
    keys_stable[2] = 1'b0; cyc(10);
    check("ovf_set", evt_overflow, 1'b1);
    ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
    check("ovf_clear", evt_overflow, 1'b0);
    keys_stable[2] = 1'b1; cyc(1);
    ovf_clr = 1'b1; cyc(1);
    check("ovf_set_wins", evt_overflow, 1'b1);
    ovf_clr = 1'b0; cyc(3);
    check("ovf_sticky", evt_overflow, 1'b1);
    ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
    check("ovf_clear2", evt_overflow, 1'b0);
    evt_ready = 1'b1;
    keys_stable = '1;
    wait_drain();
    seen_q.delete();

    // Reset with queued events while key 4 is held
    evt_ready = 1'b0;
    keys_stable = 8'b1110_0001;
    cyc(10);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", evt_valid, 1'b0);
    #1;
    keys_stable = 8'b1110_1111;
    cyc(3);
    seen_q.delete();
    evt_ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("rst_lat_n2", evt_valid, 1'b0);
    @(posedge clk); #1;
    check("rst_lat_n3", evt_valid, 1'b1);
    check("rst_head", {evt_key, evt_type}, ent(4, 0));
    #1;
    cyc(10);
    want(4, 0);
    expect_seen("rst_single");
    keys_stable = '1;
    wait_drain();
    seen_q.delete();

    // Randomized key activity with bursty consumer and a mid-run reset
    for (int k = 0; k < KEY_CNT; k++) rem[k] = $urandom_range(3, 60);
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < KEY_CNT; k++) begin
        if (rem[k] == 0) begin
          keys_stable[k] = ~keys_stable[k];
          rem[k] = $urandom_range(3, 160);
        end else rem[k]--;
      end
      if (c >= 1000 && c < 1300) evt_ready = 1'b0;
      else                       evt_ready = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 49) == 0);
      if (c == 2000) rst_n = 1'b0;
      if (c == 2003) rst_n = 1'b1;
      cyc(1);
    end
    ovf_clr = 1'b0;
    evt_ready = 1'b1;
    keys_stable = '1;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
